// File: rtl/barrett_mod_reduce_pipe.sv
`default_nettype none
// ============================================================================
// Module      : barrett_mod_reduce_pipe
// Description : Three-stage pipelined Barrett reducer. Takes a 2N-bit product
//               and returns product mod Q. A sideband tag travels with each
//               beat. Valid/ready flow control on both sides, driven by a
//               single global advance enable.
// Revision    : 1.0 - initial release
// ============================================================================
module barrett_mod_reduce_pipe #(
    parameter int N     = 16,
    parameter int Q     = 12289,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*N-1:0]   in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic [TAG_W-1:0] out_tag
);

    // Barrett constant floor(2^(2N)/Q). Q above 2^(N-3) keeps MU within N+3
    // bits, so x*MU fits in 3N+3 bits without truncation.
    localparam logic [63:0]      c_POW2N = 64'd1 << (2*N);
    localparam logic [3*N+2:0]   MU      = (3*N+3)'(c_POW2N / 64'(Q));
    localparam logic [N+1:0]     c_Q1    = (N+2)'(Q);
    localparam logic [N+1:0]     c_Q2    = (N+2)'(2*Q);

    // Stage 1: low bits of x (the only ones needed once the quotient is known),
    // and the quotient estimate qh = (x*MU) >> 2N.
    logic             r_s1_valid;
    logic [N+1:0]     r_s1_xl;
    logic [N+2:0]     r_s1_qh;
    logic [TAG_W-1:0] r_s1_tag;

    // Stage 2: partial remainder r = x - qh*Q, always below 3Q.
    logic             r_s2_valid;
    logic [N+1:0]     r_s2_r;
    logic [TAG_W-1:0] r_s2_tag;

    // Stage 3: output register.
    logic             r_out_valid;
    logic [N-1:0]     r_out_data;
    logic [TAG_W-1:0] r_out_tag;

    logic             w_adv;
    logic [3*N+2:0]   w_t;
    logic [N+2:0]     w_qh;
    logic [N+1:0]     w_qhq;
    logic [N+1:0]     w_r;
    logic [N-1:0]     w_res;

    // The whole pipe moves together whenever the output slot can drain.
    assign w_adv    = !r_out_valid | out_ready;
    assign in_ready = w_adv;

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_tag   = r_out_tag;

    // Full-width product; only the part above bit 2N is kept.
    assign w_t  = (3*N+3)'(in_data) * MU;
    assign w_qh = (N+3)'(w_t >> (2*N));

    // Since r < 3Q < 2^(N+2), working modulo 2^(N+2) gives the exact value.
    assign w_qhq = (N+2)'(r_s1_qh) * c_Q1;
    assign w_r   = r_s1_xl - w_qhq;

    // Final correction: subtract Q at most twice to land in [0, Q).
    always_comb begin
        w_res = r_s2_r[N-1:0];
        if (r_s2_r >= c_Q2) begin
            w_res = N'(r_s2_r - c_Q2);
        end else if (r_s2_r >= c_Q1) begin
            w_res = N'(r_s2_r - c_Q1);
        end
    end

    // Valid bits: shift on advance, cleared by flush regardless of advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid  <= in_valid;
            r_s2_valid  <= r_s1_valid;
            r_out_valid <= r_s2_valid;
        end
    end

    // Stage 1 data: load only a real beat so idle cycles leave it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_xl  <= '0;
            r_s1_qh  <= '0;
            r_s1_tag <= '0;
        end else if (w_adv && !flush && in_valid) begin
            r_s1_xl  <= in_data[N+1:0];
            r_s1_qh  <= w_qh;
            r_s1_tag <= in_tag;
        end
    end

    // Stage 2 data: partial remainder and tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_r   <= '0;
            r_s2_tag <= '0;
        end else if (w_adv && !flush && r_s1_valid) begin
            r_s2_r   <= w_r;
            r_s2_tag <= r_s1_tag;
        end
    end

    // Output data: holds while stalled, so it stays stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data <= '0;
            r_out_tag  <= '0;
        end else if (w_adv && !flush && r_s2_valid) begin
            r_out_data <= w_res;
            r_out_tag  <= r_s2_tag;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_barrett_mod_reduce_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_barrett_mod_reduce_pipe
// Description : Self-checking bench for barrett_mod_reduce_pipe (N=16,
//               Q=12289). Directed vector table plus streaming, backpressure,
//               flush and asynchronous reset sequences with a scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_barrett_mod_reduce_pipe;

    localparam int N     = 16;
    localparam int Q     = 12289;
    localparam int TAG_W = 8;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             flush     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [2*N-1:0]   in_data   = '0;
    logic [TAG_W-1:0] in_tag    = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [N-1:0]     out_data;
    logic [TAG_W-1:0] out_tag;

    barrett_mod_reduce_pipe #(
        .N     (N),
        .Q     (Q),
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x;
        logic [7:0]  tag;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        logic [15:0] d;
        logic [7:0]  t;
    } exp_t;

    vec_t vecs[5];
    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    logic took   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: sample the handshake before the edge, update the scoreboard after it.
    task automatic tick();
        logic        ti;
        logic        to;
        logic        stall;
        logic        fl;
        logic [15:0] od;
        logic [7:0]  ot;
        logic [31:0] xd;
        logic [7:0]  xt;
        longint unsigned xm;
        exp_t        e;
        #1;
        ti    = in_valid & in_ready & !flush;
        to    = out_valid & out_ready;
        stall = out_valid & !out_ready;
        fl    = flush;
        od    = out_data;
        ot    = out_tag;
        xd    = in_data;
        xt    = in_tag;
        chk("in_ready_vs_adv", 32'(in_ready), 32'(!stall));
        @(posedge clk);
        #1;
        if (to) begin
            if (sbq.size() == 0) begin
                chk("spurious_output", 32'(1), 32'(0));
            end else begin
                e = sbq.pop_front();
                chk("sb_data", 32'(od), 32'(e.d));
                chk("sb_tag", 32'(ot), 32'(e.t));
            end
        end
        if (fl) sbq.delete();
        if (ti) begin
            xm  = 64'(xd) % 64'(Q);
            e.d = 16'(xm);
            e.t = xt;
            sbq.push_back(e);
        end
        took = ti;
        if (stall && !fl) begin
            chk("stall_valid", 32'(out_valid), 32'(1));
            chk("stall_data", 32'(out_data), 32'(od));
            chk("stall_tag", 32'(out_tag), 32'(ot));
        end
    endtask

    // Send one beat into an idle pipe and measure its latency and result.
    task automatic single_beat(input vec_t v);
        int lat;
        in_data   = v.x;
        in_tag    = v.tag;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("beat_accepted", 32'(took), 32'(1));
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        chk("latency", 32'(lat), 32'(3));
        chk("vec_data", 32'(out_data), 32'(v.exp));
        chk("vec_tag", 32'(out_tag), 32'(v.tag));
        tick();
        chk("single_out_drained", 32'(out_valid), 32'(0));
    endtask

    // Stream n random beats, optionally stalling the output for a window.
    task automatic stream(input int n, input int stall_start, input int stall_len);
        int          c;
        int          sent;
        logic [31:0] x;
        c    = 0;
        sent = 0;
        x    = $urandom;
        while ((sent < n || sbq.size() != 0) && c < n + 100) begin
            out_ready = !(c >= stall_start && c < stall_start + stall_len);
            if (sent < n) begin
                in_valid = 1'b1;
                in_data  = x;
                in_tag   = sent[7:0];
            end else begin
                in_valid = 1'b0;
            end
            tick();
            c++;
            if (took) begin
                sent++;
                x = $urandom;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_cycles", 32'(c), 32'(n + 3 + stall_len));
        chk("stream_drained", 32'(sbq.size()), 32'(0));
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{x: 32'd0,          tag: 8'h11, exp: 16'd0};
        vecs[1] = '{x: 32'd12289,      tag: 8'h22, exp: 16'd0};
        vecs[2] = '{x: 32'd12290,      tag: 8'h33, exp: 16'd1};
        vecs[3] = '{x: 32'd150994944,  tag: 8'h44, exp: 16'd1};
        vecs[4] = '{x: 32'hFFFF_FFFF,  tag: 8'h55, exp: 16'd10951};

        // Reset state
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'(0));
        chk("reset_out_data", 32'(out_data), 32'(0));
        chk("reset_out_tag", 32'(out_tag), 32'(0));
        chk("reset_in_ready", 32'(in_ready), 32'(1));

        // Directed single beats
        for (int i = 0; i < 5; i++) begin
            single_beat(vecs[i]);
        end

        // Back-to-back streaming, no gaps
        stream(1000, 100000, 0);

        // Backpressure: 6 beats, 4-cycle output stall
        stream(6, 4, 4);

        // Flush with three beats in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'd1000 + 32'(i);
            in_tag   = 8'(8'hA0 + i);
            tick();
            chk("flush_fill_accept", 32'(took), 32'(1));
        end
        in_data = 32'd777;
        in_tag  = 8'hEE;
        flush   = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'(0));
        chk("flush_drop_input", 32'(took), 32'(0));
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("flush_quiet", 32'(out_valid), 32'(0));
        end
        single_beat(vecs[4]);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 32'd50000 + 32'(i);
            in_tag   = 8'(8'hC0 + i);
            tick();
        end
        chk("pre_reset_busy", 32'(out_valid), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'(0));
        chk("async_rst_out_data", 32'(out_data), 32'(0));
        chk("async_rst_in_ready", 32'(in_ready), 32'(1));
        sbq.delete();
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_reset_quiet", 32'(out_valid), 32'(0));
        end
        single_beat(vecs[2]);
        single_beat(vecs[3]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
